// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus DDR output bank.
package hyperbus_pkg;

    // Width of the preamble/postamble cycle counter (supports 0..15 cycles).
    localparam int CNT_W = 4;

    // Output sequencer states. The state register names what the pads show
    // during the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ACTIVE,
        ST_POST
    } state_e;

endpackage

// File: rtl/hyperbus_ddr_clk_mux.sv
// Per-lane DDR select: clock high shows d0, clock low shows d1. Stands in
// for the glitch-free clock mux cell of the target library.
module hyperbus_ddr_clk_mux (
    input  logic i_clk,
    input  logic i_d0,
    input  logic i_d1,
    output logic o_q
);

    assign o_q = i_clk ? i_d0 : i_d1;

endmodule

// File: rtl/hyperbus_ddr_tx_fifo.sv
// Small synchronous FIFO holding {d0, d1, last} beat pairs for the DDR bank.
module hyperbus_ddr_tx_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_wdata,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH+1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [FW-1:0] r_fill;
    logic          w_push;
    logic          w_pop;

    // Full and empty come straight from the occupancy count, so a pop never
    // frees a slot for a push in the same cycle.
    assign o_full  = (r_fill == FW'(DEPTH));
    assign o_empty = (r_fill == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd];
    assign o_fill  = r_fill;

    // Pointer and occupancy bookkeeping; flush behaves like reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
            else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst && !i_flush) r_mem[r_wr] <= i_wdata;
    end

endmodule

// File: rtl/hyperbus_ddr_out_bank.sv
// Multi-lane SDR-to-DDR output stage: FIFO, preamble/postamble sequencer,
// registered output enable and per-lane DDR muxes.
module hyperbus_ddr_out_bank
    import hyperbus_pkg::*;
#(
    parameter int   WIDTH         = 8,
    parameter int   DEPTH         = 4,
    parameter logic INIT          = 1'b0,
    parameter int   PRE_CYCLES    = 1,
    parameter int   POST_CYCLES   = 1,
    parameter logic UNDERRUN_HOLD = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_d0_i,
    input  logic [WIDTH-1:0]           in_d1_i,
    input  logic                       in_last_i,
    output logic [WIDTH-1:0]           q_o,
    output logic                       oe_o,
    output logic                       busy_o,
    output logic                       underrun_o,
    output logic [$clog2(DEPTH+1)-1:0] fill_o
);

    localparam int DW = 2*WIDTH + 1;
    localparam logic [WIDTH-1:0] INIT_V  = {WIDTH{INIT}};
    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES  > 0 ? PRE_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYCLES > 0 ? POST_CYCLES - 1 : 0);

    state_e             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [WIDTH-1:0]   r_q0, r_q1, w_nxt_q0, w_nxt_q1;
    logic               r_oe, r_und, w_nxt_und;
    logic               r_end, w_nxt_end;
    logic               w_beat, w_pop, w_full, w_empty;
    logic [DW-1:0]      w_rdata;
    logic [WIDTH-1:0]   w_rd0, w_rd1;
    logic               w_rlast;

    hyperbus_ddr_tx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (flush_i),
        .i_push  (in_valid_i),
        .i_wdata ({in_d0_i, in_d1_i, in_last_i}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (fill_o)
    );

    assign w_rd0   = w_rdata[DW-1 -: WIDTH];
    assign w_rd1   = w_rdata[WIDTH:1];
    assign w_rlast = w_rdata[0];

    // Next-state and next-output decode. w_beat marks a cycle that shows a
    // data slot: a popped beat, or an underrun filler when the FIFO is dry.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_q0    = INIT_V;
        w_nxt_q1    = INIT_V;
        w_nxt_und   = 1'b0;
        w_nxt_end   = 1'b0;
        w_beat      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (PRE_CYCLES > 0) begin
                        w_nxt_state = ST_PRE;
                        w_nxt_cnt   = PRE_LD;
                    end else begin
                        w_beat = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (r_cnt == '0) w_beat = 1'b1;
                else             w_nxt_cnt = r_cnt - 1'b1;
            end
            ST_ACTIVE: begin
                if (r_end) begin
                    if (POST_CYCLES > 0) begin
                        w_nxt_state = ST_POST;
                        w_nxt_cnt   = POST_LD;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_beat = 1'b1;
                end
            end
            ST_POST: begin
                if (r_cnt == '0) w_nxt_state = ST_IDLE;
                else             w_nxt_cnt = r_cnt - 1'b1;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        if (w_beat) begin
            w_nxt_state = ST_ACTIVE;
            if (!w_empty) begin
                w_pop     = 1'b1;
                w_nxt_q0  = w_rd0;
                w_nxt_q1  = w_rd1;
                w_nxt_end = w_rlast;
            end else begin
                w_nxt_und = 1'b1;
                if (UNDERRUN_HOLD) begin
                    w_nxt_q0 = r_q0;
                    w_nxt_q1 = r_q1;
                end
            end
        end
    end

    // State, counter and pad registers; oe follows the state it enters so
    // it rises on the same edge as the first preamble or data value.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_q0    <= INIT_V;
            r_q1    <= INIT_V;
            r_oe    <= 1'b0;
            r_und   <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_q0    <= w_nxt_q0;
            r_q1    <= w_nxt_q1;
            r_oe    <= (w_nxt_state != ST_IDLE);
            r_und   <= w_nxt_und;
            r_end   <= w_nxt_end;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        hyperbus_ddr_clk_mux u_mux (
            .i_clk (clk_i),
            .i_d0  (r_q0[g]),
            .i_d1  (r_q1[g]),
            .o_q   (q_o[g])
        );
    end

    assign oe_o       = r_oe;
    assign underrun_o = r_und;
    assign in_ready_o = !w_full;
    assign busy_o     = (r_state != ST_IDLE) || !w_empty;

endmodule
